// File: rtl/byte_word_packer.sv
// Packs consecutive bus bytes (LSB first) into words and queues them in a small
// output FIFO with a ready/valid port; words arriving while the FIFO is full are dropped.
module byte_word_packer #(
   parameter int BYTES_PER_WORD = 4,
   parameter int FIFO_DEPTH     = 4,
   parameter int DROP_CNT_W     = 8
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic [7:0]                          in_data,
   input  logic                                in_valid,
   input  logic                                flush,
   output logic [8*BYTES_PER_WORD-1:0]         out_data,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [$clog2(FIFO_DEPTH):0]         fifo_level,
   output logic [$clog2(BYTES_PER_WORD)-1:0]   byte_idx,
   output logic                                overflow,
   output logic [DROP_CNT_W-1:0]               drop_count
);

   localparam int IDX_W  = $clog2(BYTES_PER_WORD);
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int LVL_W  = PTR_W + 1;
   localparam int WORD_W = 8 * BYTES_PER_WORD;
   localparam int PART_W = 8 * (BYTES_PER_WORD - 1);

   localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(BYTES_PER_WORD - 1);
   localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
   localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
   localparam logic [LVL_W-1:0] LVL_ZERO  = LVL_W'(0);

   logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      r_wr_ptr;
   logic [PTR_W-1:0]      r_rd_ptr;
   logic [LVL_W-1:0]      r_level;
   logic                  r_valid;
   logic [WORD_W-1:0]     r_head;
   logic [IDX_W-1:0]      r_idx;
   logic [PART_W-1:0]     r_partial;
   logic                  r_overflow;
   logic [DROP_CNT_W-1:0] r_drop;

   logic                  w_pop;
   logic                  w_complete;
   logic                  w_push;
   logic                  w_drop;
   logic [WORD_W-1:0]     w_word;
   logic [PTR_W-1:0]      w_rd_inc;
   logic [LVL_W-1:0]      w_level_nxt;
   logic [WORD_W-1:0]     w_head_nxt;

   // Push/pop decision and next-state of the FIFO head register
   always_comb begin
      w_pop       = r_valid && out_ready;
      w_complete  = in_valid && !flush && (r_idx == IDX_LAST);
      w_word      = {in_data, r_partial};
      w_push      = w_complete && ((r_level < LVL_FULL) || w_pop);
      w_drop      = w_complete && !w_push;
      w_rd_inc    = r_rd_ptr + PTR_W'(1);
      w_level_nxt = r_level;
      w_head_nxt  = r_head;

      case ({w_push, w_pop})
         2'b10:   w_level_nxt = r_level + LVL_ONE;
         2'b01:   w_level_nxt = r_level - LVL_ONE;
         default: w_level_nxt = r_level;
      endcase

      // With one word left and a simultaneous push, the new word becomes head directly
      if (w_pop) begin
         if (r_level > LVL_ONE) begin
            w_head_nxt = r_mem[w_rd_inc];
         end else if (w_push) begin
            w_head_nxt = w_word;
         end else begin
            w_head_nxt = r_head;
         end
      end else if (w_push && (r_level == LVL_ZERO)) begin
         w_head_nxt = w_word;
      end else begin
         w_head_nxt = r_head;
      end
   end

   // Byte assembly of the partial word
   always_ff @(posedge clk) begin
      if (reset) begin
         r_idx     <= '0;
         r_partial <= '0;
      end else if (flush) begin
         r_idx     <= '0;
      end else if (in_valid) begin
         if (w_complete) begin
            r_idx <= '0;
         end else begin
            r_idx <= r_idx + IDX_W'(1);
         end
         for (int k = 0; k < BYTES_PER_WORD - 1; k++) begin
            if (r_idx == IDX_W'(k)) begin
               r_partial[8*k +: 8] <= in_data;
            end
         end
      end else begin
         r_idx <= r_idx;
      end
   end

   // Word FIFO storage, pointers, level and registered head
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            r_mem[i] <= '0;
         end
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
         r_valid  <= 1'b0;
         r_head   <= '0;
      end else begin
         if (w_push) begin
            r_mem[r_wr_ptr] <= w_word;
            r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= w_rd_inc;
         end
         r_level <= w_level_nxt;
         r_valid <= (w_level_nxt != LVL_ZERO);
         r_head  <= w_head_nxt;
      end
   end

   // Sticky overflow flag and saturating drop counter
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow <= 1'b0;
         r_drop     <= '0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
         if (r_drop != {DROP_CNT_W{1'b1}}) begin
            r_drop <= r_drop + DROP_CNT_W'(1);
         end
      end else begin
         r_overflow <= r_overflow;
      end
   end

   assign out_data   = r_head;
   assign out_valid  = r_valid;
   assign fifo_level = r_level;
   assign byte_idx   = r_idx;
   assign overflow   = r_overflow;
   assign drop_count = r_drop;

endmodule

// File: tb/tb_byte_word_packer.sv
// Directed self-checking bench for byte_word_packer: default instance plus a
// second instance with a 2-bit drop counter for saturation.
module tb_byte_word_packer;

   logic        clk = 1'b0;
   logic        reset, in_valid, flush, out_ready;
   logic [7:0]  in_data;
   logic [31:0] out_data;
   logic        out_valid, overflow;
   logic [2:0]  fifo_level;
   logic [1:0]  byte_idx;
   logic [7:0]  drop_count;

   logic        s_reset, s_in_valid, s_flush, s_out_ready;
   logic [7:0]  s_in_data;
   logic [31:0] s_out_data;
   logic        s_out_valid, s_overflow;
   logic [2:0]  s_fifo_level;
   logic [1:0]  s_byte_idx;
   logic [1:0]  s_drop_count;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   byte_word_packer #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4), .DROP_CNT_W(8)) dut (
      .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid), .flush(flush),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .fifo_level(fifo_level), .byte_idx(byte_idx), .overflow(overflow),
      .drop_count(drop_count)
   );

   byte_word_packer #(.BYTES_PER_WORD(4), .FIFO_DEPTH(4), .DROP_CNT_W(2)) dut_sat (
      .clk(clk), .reset(s_reset), .in_data(s_in_data), .in_valid(s_in_valid), .flush(s_flush),
      .out_data(s_out_data), .out_valid(s_out_valid), .out_ready(s_out_ready),
      .fifo_level(s_fifo_level), .byte_idx(s_byte_idx), .overflow(s_overflow),
      .drop_count(s_drop_count)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] b);
      in_data  = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
   endtask

   task automatic send_sat(input logic [7:0] b);
      s_in_data  = b;
      s_in_valid = 1'b1;
      tick();
      s_in_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL rst_valid got=%0h want=0", out_valid); end
      total++; if (out_data !== 32'h0)    begin bad++; $display("FAIL rst_data got=%0h want=0", out_data); end
      total++; if (fifo_level !== 3'd0)   begin bad++; $display("FAIL rst_level got=%0d want=0", fifo_level); end
      total++; if (byte_idx !== 2'd0)     begin bad++; $display("FAIL rst_idx got=%0d want=0", byte_idx); end
      total++; if (overflow !== 1'b0)     begin bad++; $display("FAIL rst_ovf got=%0h want=0", overflow); end
      total++; if (drop_count !== 8'd0)   begin bad++; $display("FAIL rst_drop got=%0d want=0", drop_count); end
   endtask

   task automatic test_basic();
      logic [7:0] bytes_v [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [1:0] idx_v   [4] = '{2'd1, 2'd2, 2'd3, 2'd0};
      do_reset();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         send(bytes_v[i]);
         total++; if (byte_idx !== idx_v[i]) begin bad++; $display("FAIL basic_idx%0d got=%0d want=%0d", i, byte_idx, idx_v[i]); end
         if (i < 3) begin
            total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid%0d got=%0h want=0", i, out_valid); end
         end
      end
      total++; if (out_valid !== 1'b1)         begin bad++; $display("FAIL basic_valid got=%0h want=1", out_valid); end
      total++; if (out_data !== 32'h44332211)  begin bad++; $display("FAIL basic_data got=%08h want=44332211", out_data); end
      tick();
      total++; if (out_valid !== 1'b0)         begin bad++; $display("FAIL basic_one_cycle got=%0h want=0", out_valid); end
      total++; if (fifo_level !== 3'd0)        begin bad++; $display("FAIL basic_level got=%0d want=0", fifo_level); end
   endtask

   task automatic test_backpressure();
      logic [31:0] exp_w [4] = '{32'h03020100, 32'h13121110, 32'h23222120, 32'h33323130};
      do_reset();
      out_ready = 1'b0;
      for (int w = 0; w < 5; w++) begin
         for (int b = 0; b < 4; b++) begin
            send(8'(16 * w + b));
         end
      end
      total++; if (fifo_level !== 3'd4)  begin bad++; $display("FAIL bp_level got=%0d want=4", fifo_level); end
      total++; if (drop_count !== 8'd1)  begin bad++; $display("FAIL bp_drop got=%0d want=1", drop_count); end
      total++; if (overflow !== 1'b1)    begin bad++; $display("FAIL bp_ovf got=%0h want=1", overflow); end
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++; if (out_valid !== 1'b1)    begin bad++; $display("FAIL bp_valid%0d got=%0h want=1", i, out_valid); end
         total++; if (out_data !== exp_w[i]) begin bad++; $display("FAIL bp_word%0d got=%08h want=%08h", i, out_data, exp_w[i]); end
         tick();
      end
      total++; if (out_valid !== 1'b0)   begin bad++; $display("FAIL bp_fifth_absent got=%0h want=0", out_valid); end
      total++; if (overflow !== 1'b1)    begin bad++; $display("FAIL bp_ovf_sticky got=%0h want=1", overflow); end
      out_ready = 1'b0;
   endtask

   task automatic test_full_pop();
      do_reset();
      out_ready = 1'b0;
      for (int w = 0; w < 4; w++) begin
         for (int b = 0; b < 4; b++) begin
            send(8'(16 * w + b));
         end
      end
      total++; if (fifo_level !== 3'd4) begin bad++; $display("FAIL fp_fill got=%0d want=4", fifo_level); end
      send(8'h40); send(8'h41); send(8'h42);
      out_ready = 1'b1;
      send(8'h43);
      out_ready = 1'b0;
      total++; if (drop_count !== 8'd0)       begin bad++; $display("FAIL fp_drop got=%0d want=0", drop_count); end
      total++; if (fifo_level !== 3'd4)       begin bad++; $display("FAIL fp_level got=%0d want=4", fifo_level); end
      total++; if (overflow !== 1'b0)         begin bad++; $display("FAIL fp_ovf got=%0h want=0", overflow); end
      total++; if (out_data !== 32'h13121110) begin bad++; $display("FAIL fp_head got=%08h want=13121110", out_data); end
      out_ready = 1'b1;
      tick(); tick(); tick();
      total++; if (out_data !== 32'h43424140) begin bad++; $display("FAIL fp_last got=%08h want=43424140", out_data); end
      tick();
      total++; if (out_valid !== 1'b0)        begin bad++; $display("FAIL fp_empty got=%0h want=0", out_valid); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      out_ready = 1'b1;
      send(8'hAA); send(8'hBB);
      reset = 1'b1;
      tick();
      reset = 1'b0;
      total++; if (byte_idx !== 2'd0)   begin bad++; $display("FAIL rm_idx got=%0d want=0", byte_idx); end
      total++; if (fifo_level !== 3'd0) begin bad++; $display("FAIL rm_level got=%0d want=0", fifo_level); end
      total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rm_valid got=%0h want=0", out_valid); end
      total++; if (overflow !== 1'b0)   begin bad++; $display("FAIL rm_ovf got=%0h want=0", overflow); end
      total++; if (drop_count !== 8'd0) begin bad++; $display("FAIL rm_drop got=%0d want=0", drop_count); end
      send(8'h01); send(8'h02); send(8'h03);
      total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rm_no_early got=%0h want=0", out_valid); end
      send(8'h04);
      total++; if (out_data !== 32'h04030201) begin bad++; $display("FAIL rm_word got=%08h want=04030201", out_data); end
      tick();
      total++; if (out_valid !== 1'b0)  begin bad++; $display("FAIL rm_single got=%0h want=0", out_valid); end
   endtask

   task automatic test_flush();
      do_reset();
      out_ready = 1'b1;
      send(8'hAA); send(8'hBB);
      flush = 1'b1;
      send(8'hCC);
      flush = 1'b0;
      total++; if (byte_idx !== 2'd0)  begin bad++; $display("FAIL fl_idx got=%0d want=0", byte_idx); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_valid got=%0h want=0", out_valid); end
      send(8'h01); send(8'h02); send(8'h03);
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_early got=%0h want=0", out_valid); end
      send(8'h04);
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL fl_out_valid got=%0h want=1", out_valid); end
      total++; if (out_data !== 32'h04030201) begin bad++; $display("FAIL fl_word got=%08h want=04030201", out_data); end
      // flush on a completing byte must not push
      send(8'h05); send(8'h06); send(8'h07);
      flush = 1'b1;
      send(8'h08);
      flush = 1'b0;
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_no_push got=%0h want=0", out_valid); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] exp_w [3] = '{32'hA3A2A1A0, 32'hB3B2B1B0, 32'hC3C2C1C0};
      logic [7:0]  hi    [3] = '{8'hA0, 8'hB0, 8'hC0};
      do_reset();
      out_ready = 1'b1;
      for (int w = 0; w < 3; w++) begin
         for (int b = 0; b < 4; b++) begin
            send(hi[w] + 8'(b));
         end
         total++; if (out_data !== exp_w[w]) begin bad++; $display("FAIL b2b_word%0d got=%08h want=%08h", w, out_data, exp_w[w]); end
      end
      total++; if (fifo_level !== 3'd1) begin bad++; $display("FAIL b2b_level got=%0d want=1", fifo_level); end
   endtask

   task automatic test_saturation();
      s_reset = 1'b1;
      tick();
      s_reset = 1'b0;
      s_out_ready = 1'b0;
      for (int w = 0; w < 12; w++) begin
         for (int b = 0; b < 4; b++) begin
            send_sat(8'(w * 4 + b));
         end
         if (w == 5) begin
            total++; if (s_drop_count !== 2'd2) begin bad++; $display("FAIL sat_mid got=%0d want=2", s_drop_count); end
         end
      end
      total++; if (s_drop_count !== 2'd3) begin bad++; $display("FAIL sat_cnt got=%0d want=3", s_drop_count); end
      total++; if (s_overflow !== 1'b1)   begin bad++; $display("FAIL sat_ovf got=%0h want=1", s_overflow); end
      total++; if (s_fifo_level !== 3'd4) begin bad++; $display("FAIL sat_level got=%0d want=4", s_fifo_level); end
      total++; if (s_out_data !== 32'h03020100) begin bad++; $display("FAIL sat_head got=%08h want=03020100", s_out_data); end
   endtask

   initial begin
      reset = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; in_data = 8'h00;
      s_reset = 1'b0; s_in_valid = 1'b0; s_flush = 1'b0; s_out_ready = 1'b0; s_in_data = 8'h00;
      tick();
      test_reset();
      test_basic();
      test_backpressure();
      test_full_pop();
      test_reset_mid();
      test_flush();
      test_back_to_back();
      test_saturation();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
